// File: rtl/vdc_pkg.sv
// Shared timing defaults and pixel word layout for the VDC video transmitter.
package vdc_pkg;

  localparam int unsigned H_TOTAL_DEF      = 342;
  localparam int unsigned H_ACTIVE_DEF     = 256;
  localparam int unsigned H_SYNC_START_DEF = 280;
  localparam int unsigned H_SYNC_LEN_DEF   = 32;
  localparam int unsigned V_TOTAL_DEF      = 262;
  localparam int unsigned V_ACTIVE_DEF     = 240;
  localparam int unsigned V_SYNC_START_DEF = 246;
  localparam int unsigned V_SYNC_LEN_DEF   = 3;

  localparam int unsigned FIFO_DEPTH = 4;

  // Pixel word: bit 8 selects sprite/background, [7:0] is the palette index.
  typedef struct packed {
    logic       sel;
    logic [7:0] index;
  } pixel_t;

  localparam pixel_t BLANK_PIX = '0;

endpackage

// File: rtl/vdc_pix_fifo.sv
// Four-entry pixel FIFO between the upstream pixel source and the dot output.
module vdc_pix_fifo
  import vdc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [8:0] din,
  output logic [8:0] dout,
  output logic       full,
  output logic       empty
);

  pixel_t     mem [FIFO_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 3'(FIFO_DEPTH));
  assign empty   = (count == 3'd0);
  // A full FIFO refuses the write even when a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset discards all queued words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= pixel_t'(din);
  end

endmodule

// File: rtl/vdc_video_tx.sv
// Dot/line timing generator that drains the pixel FIFO onto the VCE pixel bus.
module vdc_video_tx
  import vdc_pkg::*;
#(
  parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
  parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned H_SYNC_START = H_SYNC_START_DEF,
  parameter int unsigned H_SYNC_LEN   = H_SYNC_LEN_DEF,
  parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
  parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
  parameter int unsigned V_SYNC_START = V_SYNC_START_DEF,
  parameter int unsigned V_SYNC_LEN   = V_SYNC_LEN_DEF
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic       in_valid,
  input  logic [8:0] in_data,
  output logic       in_ready,
  output logic [8:0] VD,
  output logic       HSYN,
  output logic       VSYN,
  output logic       frame_start,
  output logic       underrun,
  input  logic       underrun_clr
);

  // Counter widths cover the total and the sync end so every compare fits.
  localparam int unsigned HW = $clog2(H_TOTAL + H_SYNC_START + H_SYNC_LEN);
  localparam int unsigned VW = $clog2(V_TOTAL + V_SYNC_START + V_SYNC_LEN);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_SYNC_START);
  localparam logic [HW-1:0] H_SE   = HW'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_SYNC_START);
  localparam logic [VW-1:0] V_SE   = VW'(V_SYNC_START + V_SYNC_LEN);

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  pixel_t        head_pix;
  logic          fifo_full;
  logic          fifo_empty;
  logic          active;
  logic          pop;
  logic          push;

  assign active   = (hcount < H_ACT) && (vcount < V_ACT);
  // Pop only from a FIFO that was already non-empty; no same-cycle bypass.
  assign pop      = pix_ce && active && !fifo_empty;
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  vdc_pix_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .dout  (head_pix),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Dot counters and the output register, all advanced on the dot enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      VD          <= '0;
      HSYN        <= 1'b1;
      VSYN        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_ce) begin
        VD          <= pop ? head_pix : BLANK_PIX;
        HSYN        <= !((hcount >= H_SS) && (hcount < H_SE));
        VSYN        <= !((vcount >= V_SS) && (vcount < V_SE));
        frame_start <= (hcount == '0) && (vcount == '0);
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + VW'(1);
        end else begin
          hcount <= hcount + HW'(1);
        end
      end
    end
  end

  // Sticky underrun flag; a clear wins over a set in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun <= 1'b0;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end else if (pix_ce && active && fifo_empty) begin
      underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vdc_video_tx.sv
// Directed self-checking bench for vdc_video_tx.
module tb_vdc_video_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_ce;
  logic       in_valid;
  logic [8:0] in_data;
  logic       in_ready;
  logic [8:0] VD;
  logic       HSYN;
  logic       VSYN;
  logic       frame_start;
  logic       underrun;
  logic       underrun_clr;

  logic       s_in_valid;
  logic [8:0] s_in_data;
  logic       s_in_ready;
  logic [8:0] s_VD;
  logic       s_HSYN;
  logic       s_VSYN;
  logic       s_frame_start;
  logic       s_underrun;
  logic       s_underrun_clr;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic        feed;
  logic        acc;
  int unsigned fs_cnt;
  int unsigned vlow_cnt;

  always #5 clk = ~clk;

  vdc_video_tx dut (
    .clk          (clk),
    .reset        (rst),
    .pix_ce       (pix_ce),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .VD           (VD),
    .HSYN         (HSYN),
    .VSYN         (VSYN),
    .frame_start  (frame_start),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  // Small geometry: 12 dots x 10 lines, hsync dots 9..10, vsync lines 7..8.
  vdc_video_tx #(
    .H_TOTAL      (12),
    .H_ACTIVE     (8),
    .H_SYNC_START (9),
    .H_SYNC_LEN   (2),
    .V_TOTAL      (10),
    .V_ACTIVE     (6),
    .V_SYNC_START (7),
    .V_SYNC_LEN   (2)
  ) dut_small (
    .clk          (clk),
    .reset        (rst),
    .pix_ce       (pix_ce),
    .in_valid     (s_in_valid),
    .in_data      (s_in_data),
    .in_ready     (s_in_ready),
    .VD           (s_VD),
    .HSYN         (s_HSYN),
    .VSYN         (s_VSYN),
    .frame_start  (s_frame_start),
    .underrun     (s_underrun),
    .underrun_clr (s_underrun_clr)
  );

  function automatic logic [8:0] b9(input logic b);
    return {8'b0, b};
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clk; optionally a dot enable. Feeder advances data after an accepted push.
  task automatic step(input logic pce);
    pix_ce = pce;
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    pix_ce = 1'b0;
    if (feed && acc) in_data = in_data + 9'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pix_ce = 1'b0; in_valid = 1'b0; in_data = '0; underrun_clr = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_underrun_clr = 1'b0; feed = 1'b0;
    #3;
    check("rst_vd",       VD,              9'h000);
    check("rst_hsyn",     b9(HSYN),        9'd1);
    check("rst_vsyn",     b9(VSYN),        9'd1);
    check("rst_fs",       b9(frame_start), 9'd0);
    check("rst_underrun", b9(underrun),    9'd0);
    check("rst_in_ready", b9(in_ready),    9'd1);
    @(posedge clk); #1; rst = 1'b0;

    // Line 0 with dot enable every 4 clk and a continuously fed FIFO
    feed = 1'b1; in_valid = 1'b1; in_data = 9'h000;
    for (int d = 0; d < 342; d++) begin
      step(1'b0); step(1'b0); step(1'b0); step(1'b1);
      check("vd_line0",   VD,              (d < 256) ? 9'(d) : 9'h000);
      check("hsyn_line0", b9(HSYN),        b9(!(d >= 280 && d < 312)));
      check("vsyn_line0", b9(VSYN),        9'd1);
      check("fs_line0",   b9(frame_start), b9(d == 0));
      if (d == 0) begin
        step(1'b0);
        check("fs_one_clk", b9(frame_start), 9'd0);
      end
      if (d == 5) begin
        step(1'b0);
        check("vd_hold", VD, 9'h005);
      end
    end
    check("no_underrun_line0", b9(underrun), 9'd0);
    feed = 1'b0; in_valid = 1'b0;

    // Two words then starvation; underrun_clr behaviour
    do_reset();
    in_valid = 1'b1; in_data = 9'h1AA; step(1'b0);
    in_data = 9'h055; step(1'b0);
    in_valid = 1'b0;
    step(1'b1);
    check("starve_vd0", VD, 9'h1AA);
    check("starve_fs",  b9(frame_start), 9'd1);
    step(1'b1);
    check("starve_vd1", VD, 9'h055);
    check("starve_ur1", b9(underrun), 9'd0);
    step(1'b1);
    check("starve_vd2", VD, 9'h000);
    check("starve_ur2", b9(underrun), 9'd1);
    underrun_clr = 1'b1; step(1'b0); underrun_clr = 1'b0;
    check("ur_clear", b9(underrun), 9'd0);
    underrun_clr = 1'b1; step(1'b1); underrun_clr = 1'b0;
    check("ur_clr_priority", b9(underrun), 9'd0);
    check("ur_clr_vd",       VD, 9'h000);
    in_valid = 1'b1; in_data = 9'h0AB; step(1'b1); in_valid = 1'b0;
    check("no_bypass_vd", VD, 9'h000);
    check("no_bypass_ur", b9(underrun), 9'd1);
    step(1'b1);
    check("no_bypass_next", VD, 9'h0AB);

    // Full FIFO refuses a push even with a same-cycle pop
    do_reset();
    in_valid = 1'b1;
    in_data = 9'h101; step(1'b0);
    in_data = 9'h102; step(1'b0);
    in_data = 9'h103; step(1'b0);
    in_data = 9'h104; step(1'b0);
    check("full_ready", b9(in_ready), 9'd0);
    in_data = 9'h105; step(1'b1);
    check("full_pop_vd",    VD, 9'h101);
    check("full_pop_ready", b9(in_ready), 9'd1);
    step(1'b0);
    check("fifth_accepted", b9(in_ready), 9'd0);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1);
      check("full_drain", VD, 9'h102 + 9'(k));
    end
    step(1'b1);
    check("full_drain_end", VD, 9'h000);
    check("full_drain_ur",  b9(underrun), 9'd1);

    // Dot enable every clk with simultaneous push/pop
    do_reset();
    in_valid = 1'b1;
    in_data = 9'h010; step(1'b0);
    in_data = 9'h011; step(1'b0);
    for (int k = 0; k < 8; k++) begin
      in_data = 9'h012 + 9'(k);
      step(1'b1);
      check("b2b_vd", VD, 9'h010 + 9'(k));
      if (k == 0) check("b2b_fs", b9(frame_start), 9'd1);
    end
    in_valid = 1'b0;
    check("b2b_ready", b9(in_ready), 9'd1);
    check("b2b_ur",    b9(underrun), 9'd0);

    // Reset mid-frame at line 100 dot 50 with three words queued
    do_reset();
    for (int i = 0; i < 34249; i++) step(1'b1);
    in_valid = 1'b1; in_data = 9'h1C3; step(1'b0); in_valid = 1'b0;
    step(1'b1);
    check("mid_vd", VD, 9'h1C3);
    in_valid = 1'b1;
    in_data = 9'h011; step(1'b0);
    in_data = 9'h022; step(1'b0);
    in_data = 9'h033; step(1'b0);
    in_valid = 1'b0;
    check("mid_ready3", b9(in_ready), 9'd1);
    check("mid_hold",   VD, 9'h1C3);
    check("mid_ur",     b9(underrun), 9'd1);
    #2; rst = 1'b1; #1;
    check("async_vd",    VD, 9'h000);
    check("async_hsyn",  b9(HSYN), 9'd1);
    check("async_vsyn",  b9(VSYN), 9'd1);
    check("async_fs",    b9(frame_start), 9'd0);
    check("async_ur",    b9(underrun), 9'd0);
    check("async_ready", b9(in_ready), 9'd1);
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    step(1'b1);
    check("post_rst_vd", VD, 9'h000);
    check("post_rst_fs", b9(frame_start), 9'd1);
    check("post_rst_ur", b9(underrun), 9'd1);
    step(1'b1);
    check("post_rst_empty", VD, 9'h000);

    // Frame timing on the reduced-geometry instance, dot enable every clk
    do_reset();
    fs_cnt = 0; vlow_cnt = 0;
    for (int k = 0; k <= 240; k++) begin
      step(1'b1);
      check("s_fs",   b9(s_frame_start), b9((k % 120) == 0));
      check("s_vsyn", b9(s_VSYN), b9(!(((k / 12) % 10) >= 7 && ((k / 12) % 10) < 9)));
      check("s_hsyn", b9(s_HSYN), b9(!((k % 12) >= 9 && (k % 12) < 11)));
      if (s_frame_start) fs_cnt++;
      if (!s_VSYN) vlow_cnt++;
    end
    check("s_fs_count",   9'(fs_cnt),   9'd3);
    check("s_vlow_count", 9'(vlow_cnt), 9'd48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vdc_video_tx.md
VDC_VIDEO_TX -- requirements
Module: vdc_video_tx

Interface
REQ-001 The block SHALL take parameter H_TOTAL, default 342, as dots per line.
REQ-002 The block SHALL take parameter H_ACTIVE, default 256, as visible dots per line.
REQ-003 The block SHALL take parameter H_SYNC_START, default 280, as the dot index at which HSYN asserts.
REQ-004 The block SHALL take parameter H_SYNC_LEN, default 32, as the HSYN width in dots.
REQ-005 The block SHALL take parameter V_TOTAL, default 262, as lines per frame.
REQ-006 The block SHALL take parameter V_ACTIVE, default 240, as visible lines.
REQ-007 The block SHALL take parameter V_SYNC_START, default 246, as the line at which VSYN asserts.
REQ-008 The block SHALL take parameter V_SYNC_LEN, default 3, as the VSYN width in lines.
REQ-009 clk  in  1  master clock; the block has one clock, and reset is asynchronous and active-high.
REQ-010 reset  in  1  asynchronous, active-high reset.
REQ-011 pix_ce  in  1  dot-clock enable, one clk wide, derived from the VCE CK divider.
REQ-012 in_valid  in  1  upstream pixel valid.
REQ-013 in_data  in  9  upstream pixel (bit 8 = sprite/bg select, [7:0] = palette index).
REQ-014 in_ready  out  1  FIFO can accept a pixel.
REQ-015 VD  out  9  pixel bus to the VCE.
REQ-016 HSYN  out  1  active-low horizontal sync.
REQ-017 VSYN  out  1  active-low vertical sync.
REQ-018 frame_start  out  1  one-clk pulse at dot 0, line 0.
REQ-019 underrun  out  1  sticky flag: active dot with empty FIFO.
REQ-020 underrun_clr  in  1  clears underrun.

Function
REQ-021 The hcount SHALL advance only on pix_ce, over 0..H_TOTAL-1, wrapping to 0, with vcount incrementing on each wrap.
REQ-022 The vcount SHALL cover 0..V_TOTAL-1 and wrap to 0 when it increments past V_TOTAL-1.
REQ-023 A dot SHALL be active when hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-024 On each pix_ce, all outputs SHALL be registered from the current counts, giving one pix_ce of latency from count to pin.
REQ-025 HSYN SHALL be 0 when H_SYNC_START<=hcount<H_SYNC_START+H_SYNC_LEN, and 1 otherwise.
REQ-026 VSYN SHALL be 0 when V_SYNC_START<=vcount<V_SYNC_START+V_SYNC_LEN, and 1 otherwise.
REQ-027 On an active dot with a non-empty FIFO, the block SHALL pop the head, and VD SHALL equal that word.
REQ-028 On an active dot with an empty FIFO, VD SHALL be 9'h000, underrun SHALL set, and counts SHALL still advance.
REQ-029 On inactive dots, VD SHALL be 9'h000 and there SHALL be no pop.
REQ-030 VD, HSYN and VSYN SHALL hold between pix_ce pulses.
REQ-031 The FIFO SHALL be 4 deep, first-in first-out, and its 9-bit words SHALL pass through unmodified.
REQ-032 in_ready SHALL be 1 exactly when the FIFO holds fewer than 4 entries.
REQ-033 A push SHALL occur when in_valid and in_ready are both 1.
REQ-034 When the FIFO is full, a push SHALL NOT be accepted even if a pop occurs in the same cycle.
REQ-035 Push and pop in the same cycle when not full SHALL leave the count unchanged and preserve order.
REQ-036 Push on an empty FIFO SHALL NOT bypass to a same-cycle pop; that dot is an underrun.
REQ-037 frame_start SHALL pulse for one clk on the pix_ce at which the registered output dot is (0,0).
REQ-038 underrun_clr SHALL take priority over a same-cycle set, so the flag reads 0.
REQ-039 Back-to-back pix_ce on every clk SHALL be supported.

Reset
REQ-040 While reset is 1, hcount=0, vcount=0 and FIFO empty SHALL hold.
REQ-041 While reset is 1, outputs SHALL be VD=0, HSYN=1, VSYN=1, frame_start=0, underrun=0 and in_ready=1.
REQ-042 Reset asserted mid-line or mid-frame SHALL discard FIFO contents immediately.
REQ-043 After reset release, the first pix_ce SHALL register dot (0,0) and pulse frame_start.

Structure
REQ-044 Package vdc_pkg SHALL hold the default timing constants and the pixel typedef (9-bit packed: sel, index[7:0]).
REQ-045 The FIFO SHALL be sub-module vdc_pix_fifo, with push/pop/full/empty, 4 x 9 storage, and 2-bit pointers plus a 3-bit count.
REQ-046 Counters, sync decode and the output register SHALL live in vdc_video_tx.

Verification
REQ-047 Reset, then pix_ce every 4 clk, FIFO kept fed with an incrementing index -> VD=0x000..0x0FF on line 0 dots 0..255, then 0x000; HSYN low for dots 280..311.
REQ-048 Run one full frame -> frame_start pulses once per 342*262=89604 pix_ce; VSYN low for lines 246..248 only.
REQ-049 Push 0x1AA and 0x055, then starve -> VD shows 0x1AA, 0x055, then 0x000 with underrun=1; pulse underrun_clr -> underrun=0.
REQ-050 Fill the FIFO to 4 with in_valid held high -> in_ready=0; a same-cycle pop does not admit the 5th word, which is accepted on the next clk.
REQ-051 Assert reset at line 100, dot 50, with 3 words queued -> outputs return to reset values within the same cycle; after release, FIFO is empty and the first dot is (0,0).
REQ-052 Run with pix_ce tied high -> counts advance every clk and the FIFO order is preserved under simultaneous push/pop.
